// File: rtl/riscv_v_writeback_if.sv
// riscv_v_writeback_if: execute offer, VRF write port, integer writeback and
// MEM/WB forwarding bundle for the vector writeback pipe.
interface riscv_v_writeback_if #(
    parameter int VLEN    = 128,
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic                 flush;
    logic                 exe_valid;
    logic                 exe_ready;
    logic [VLEN-1:0]      exe_data;
    logic [VLEN/8-1:0]    exe_be;
    logic [RADDR_W-1:0]   exe_rd;
    logic                 exe_is_v2i;
    logic [XLEN-1:0]      exe_int_data;
    logic [RADDR_W-1:0]   exe_int_rd;
    logic [VLEN/8-1:0]    rf_wr_en_mem;
    logic [RADDR_W-1:0]   rf_wr_addr_mem;
    logic [VLEN-1:0]      rf_wr_data_mem;
    logic [VLEN/8-1:0]    rf_wr_en_wb;
    logic [RADDR_W-1:0]   rf_wr_addr_wb;
    logic [VLEN-1:0]      rf_wr_data_wb;
    logic                 vrf_wr_en;
    logic                 vrf_wr_ready;
    logic [VLEN/8-1:0]    vrf_wr_be;
    logic [RADDR_W-1:0]   vrf_wr_addr;
    logic [VLEN-1:0]      vrf_wr_data;
    logic                 int_wb_valid;
    logic                 int_wb_ready;
    logic [XLEN-1:0]      int_wb_data;
    logic [RADDR_W-1:0]   int_wb_rd;

    modport master (
        output flush, exe_valid, exe_data, exe_be, exe_rd, exe_is_v2i, exe_int_data, exe_int_rd,
               vrf_wr_ready, int_wb_ready,
        input  exe_ready, rf_wr_en_mem, rf_wr_addr_mem, rf_wr_data_mem,
               rf_wr_en_wb, rf_wr_addr_wb, rf_wr_data_wb,
               vrf_wr_en, vrf_wr_be, vrf_wr_addr, vrf_wr_data,
               int_wb_valid, int_wb_data, int_wb_rd
    );

    modport slave (
        input  flush, exe_valid, exe_data, exe_be, exe_rd, exe_is_v2i, exe_int_data, exe_int_rd,
               vrf_wr_ready, int_wb_ready,
        output exe_ready, rf_wr_en_mem, rf_wr_addr_mem, rf_wr_data_mem,
               rf_wr_en_wb, rf_wr_addr_wb, rf_wr_data_wb,
               vrf_wr_en, vrf_wr_be, vrf_wr_addr, vrf_wr_data,
               int_wb_valid, int_wb_data, int_wb_rd
    );
endinterface

// File: rtl/riscv_v_writeback.sv
// riscv_v_writeback: MEM/WB vector writeback pipe with VRF write port, v2i int FIFO and forwarding.
// RISCV_V_WB_INT_FIFO_EN selects a 2-entry int FIFO instead of a single register.
module riscv_v_writeback #(
    parameter int VLEN    = 128,
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input logic           clk,
    input logic           rst,
    riscv_v_writeback_if.slave bus
);
    localparam int BW = VLEN / 8;
`ifdef RISCV_V_WB_INT_FIFO_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [VLEN-1:0]    data;
        logic [BW-1:0]      be;
        logic [RADDR_W-1:0] rd;
        logic               is_v2i;
        logic [XLEN-1:0]    int_data;
        logic [RADDR_W-1:0] int_rd;
    } stage_t;

    stage_t                     exe, mem, wb;
    logic                       mem_valid, wb_valid;
    logic [XLEN+RADDR_W-1:0]    q [DEPTH];
    logic [1:0]                 cnt;
    logic                       vec_need, int_can, wb_done, wb_adv, push, pop;

    assign exe = {bus.exe_data, bus.exe_be, bus.exe_rd, bus.exe_is_v2i, bus.exe_int_data, bus.exe_int_rd};
    assign vec_need = !wb.is_v2i && wb.be != '0;
    assign pop = cnt != 2'd0 && bus.int_wb_ready;
    // A lone register may refill in the cycle it drains; the 2-entry FIFO never pushes while full.
    assign int_can = cnt != 2'(DEPTH) || (DEPTH == 1 && bus.int_wb_ready);
    assign wb_done = vec_need ? bus.vrf_wr_ready : (!wb.is_v2i || int_can);
    assign wb_adv = !wb_valid || wb_done;
    assign push = wb_valid && wb.is_v2i && int_can;
    assign bus.exe_ready = !mem_valid || wb_adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
            mem       <= '0;
            wb        <= '0;
        end else begin
            if (wb_adv) wb_valid <= mem_valid && !bus.flush;
            if (wb_adv && mem_valid && !bus.flush) wb <= mem;
            if (bus.flush) mem_valid <= 1'b0;
            else if (bus.exe_ready) mem_valid <= bus.exe_valid;
            if (bus.exe_valid && bus.exe_ready && !bus.flush) mem <= exe;
        end
    end

    // Head-at-zero shift FIFO: pops shift down, a push lands just past the surviving entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(pop);
            for (int i = 0; i < DEPTH; i++) begin
                if (push && i == int'(cnt) - int'(pop)) q[i] <= {wb.int_data, wb.int_rd};
                else if (pop) q[i] <= q[(i + 1) % DEPTH];
            end
        end
    end

    assign bus.rf_wr_en_mem   = mem_valid && !mem.is_v2i ? mem.be : '0;
    assign bus.rf_wr_addr_mem = mem.rd;
    assign bus.rf_wr_data_mem = mem.data;
    assign bus.rf_wr_en_wb    = wb_valid && !wb.is_v2i ? wb.be : '0;
    assign bus.rf_wr_addr_wb  = wb.rd;
    assign bus.rf_wr_data_wb  = wb.data;
    assign bus.vrf_wr_en      = wb_valid && vec_need;
    assign bus.vrf_wr_be      = wb.be;
    assign bus.vrf_wr_addr    = wb.rd;
    assign bus.vrf_wr_data    = wb.data;
    assign bus.int_wb_valid   = cnt != 2'd0;
    assign {bus.int_wb_data, bus.int_wb_rd} = q[0];
endmodule

// File: tb/tb_riscv_v_writeback.sv
// tb_riscv_v_writeback: randomized and directed checks of the writeback pipe
// against a transaction-queue model of the in-flight entries and the int FIFO.
module tb_riscv_v_writeback;
    localparam int VLEN = 128;
    localparam int XLEN = 32;
    localparam int RW   = 5;
`ifdef RISCV_V_WB_INT_FIFO_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [VLEN-1:0] data;
        logic [15:0]     be;
        logic [RW-1:0]   rd;
        logic            v2i;
        logic [XLEN-1:0] idata;
        logic [RW-1:0]   ird;
        logic            at_wb;
    } ent_t;

    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;

    riscv_v_writeback_if #(.VLEN(VLEN), .XLEN(XLEN), .RADDR_W(RW)) bus();
    riscv_v_writeback #(.VLEN(VLEN), .XLEN(XLEN), .RADDR_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    ent_t pipe[$];
    logic [XLEN+RW-1:0] ifq[$];
    int vlog_rd[$], vlog_cyc[$], ilog[$];
    bit rdy_log[$];

    task automatic chk(string n, logic [VLEN-1:0] a, logic [VLEN-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h cycle=%0d", n, a, e, cyc_n);
        end
    endtask

    // Compare this cycle's outputs against the model, then advance the model across the edge.
    task automatic step_model();
        ent_t w, m, e;
        bit hw, hm, vec, iok, done, adv, er;
        w = '0;
        m = '0;
        hw = pipe.size() > 0 && pipe[0].at_wb;
        hm = pipe.size() > 0 && !pipe[pipe.size()-1].at_wb;
        if (hw) w = pipe[0];
        if (hm) m = pipe[pipe.size()-1];
        vec = hw && !w.v2i && w.be != 0;
        iok = (CAP == 2) ? ifq.size() < 2 : (ifq.size() == 0 || bus.int_wb_ready);
        done = vec ? bus.vrf_wr_ready : (!w.v2i || iok);
        adv = !hw || done;
        er = !hm || adv;
        rdy_log.push_back(er);
        chk("exe_ready", bus.exe_ready, er);
        chk("vrf_wr_en", bus.vrf_wr_en, vec);
        if (vec) begin
            chk("vrf_wr_addr", bus.vrf_wr_addr, w.rd);
            chk("vrf_wr_be", bus.vrf_wr_be, w.be);
            chk("vrf_wr_data", bus.vrf_wr_data, w.data);
        end
        chk("rf_wr_en_mem", bus.rf_wr_en_mem, (hm && !m.v2i) ? m.be : 16'h0);
        if (hm && !m.v2i && m.be != 0) begin
            chk("rf_wr_addr_mem", bus.rf_wr_addr_mem, m.rd);
            chk("rf_wr_data_mem", bus.rf_wr_data_mem, m.data);
        end
        chk("rf_wr_en_wb", bus.rf_wr_en_wb, (hw && !w.v2i) ? w.be : 16'h0);
        if (vec) begin
            chk("rf_wr_addr_wb", bus.rf_wr_addr_wb, w.rd);
            chk("rf_wr_data_wb", bus.rf_wr_data_wb, w.data);
        end
        chk("int_wb_valid", bus.int_wb_valid, ifq.size() != 0);
        if (ifq.size() != 0) chk("int_wb_payload", {bus.int_wb_data, bus.int_wb_rd}, ifq[0]);
        if (ifq.size() != 0 && bus.int_wb_ready) ilog.push_back(int'(ifq.pop_front() >> RW));
        if (hw && done) begin
            if (w.v2i) ifq.push_back({w.idata, w.ird});
            if (vec) begin
                vlog_rd.push_back(int'(w.rd));
                vlog_cyc.push_back(cyc_n);
            end
            void'(pipe.pop_front());
        end
        if (hm) begin
            if (bus.flush) void'(pipe.pop_back());
            else if (adv) pipe[pipe.size()-1].at_wb = 1'b1;
        end
        if (bus.exe_valid && er && !bus.flush) begin
            e = {bus.exe_data, bus.exe_be, bus.exe_rd, bus.exe_is_v2i, bus.exe_int_data, bus.exe_int_rd, 1'b0};
            pipe.push_back(e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        step_model();
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int rd, logic [15:0] be, bit v2i, logic [31:0] idata);
        bus.exe_valid    = v;
        bus.exe_rd       = rd[RW-1:0];
        bus.exe_be       = be;
        bus.exe_is_v2i   = v2i;
        bus.exe_int_data = idata;
        bus.exe_int_rd   = rd[RW-1:0];
        bus.exe_data     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        chk("rst_exe_ready", bus.exe_ready, 1);
        chk("rst_vrf_wr_en", bus.vrf_wr_en, 0);
        chk("rst_rf_wr_en_mem", bus.rf_wr_en_mem, 0);
        chk("rst_rf_wr_en_wb", bus.rf_wr_en_wb, 0);
        chk("rst_int_wb_valid", bus.int_wb_valid, 0);
        chk("rst_vrf_wr_data", bus.vrf_wr_data, 0);
        chk("rst_vrf_wr_addr", bus.vrf_wr_addr, 0);
        chk("rst_int_wb_data", bus.int_wb_data, 0);
        pipe.delete();
        ifq.delete();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic exp_w(string n, int idx, int rd, int c);
        chk({n, "_present"}, vlog_rd.size() > idx, 1);
        if (idx < vlog_rd.size()) begin
            chk({n, "_rd"}, vlog_rd[idx], rd);
            chk({n, "_cyc"}, vlog_cyc[idx], c);
        end
    endtask

    initial begin
        int c0, n0, i0;
        bus.flush = 0;
        bus.vrf_wr_ready = 1;
        bus.int_wb_ready = 1;
        drive(0, 0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // stream rd 1..4 at full rate
        c0 = cyc_n; n0 = vlog_rd.size();
        for (int r = 1; r <= 4; r++) begin drive(1, r, 16'hFFFF, 0, r); cyc(); end
        drive(0, 0, 16'h0, 0, 0);
        repeat (4) cyc();
        chk("d2_count", vlog_rd.size() - n0, 4);
        for (int k = 0; k < 4; k++) exp_w("d2", n0 + k, k + 1, c0 + 2 + k);

        // reset with two results in flight, then a single result after reset
        drive(1, 20, 16'h00FF, 0, 0); cyc();
        drive(1, 21, 16'hFF00, 0, 0); cyc();
        do_reset();
        c0 = cyc_n; n0 = vlog_rd.size();
        drive(1, 9, 16'hFFFF, 0, 9); cyc();
        drive(0, 0, 16'h0, 0, 0);
        repeat (3) cyc();
        chk("d1_count", vlog_rd.size() - n0, 1);
        exp_w("d1", n0, 9, c0 + 2);

        // VRF backpressure with MEM and WB full
        bus.vrf_wr_ready = 0;
        c0 = cyc_n; n0 = vlog_rd.size();
        drive(1, 5, 16'hFFFF, 0, 0); cyc();
        drive(1, 6, 16'hFFFF, 0, 0); cyc();
        drive(1, 7, 16'hFFFF, 0, 0);
        repeat (3) cyc();
        for (int k = 2; k <= 4; k++) chk("d3_stall", rdy_log[c0 + k], 0);
        bus.vrf_wr_ready = 1;
        drive(0, 0, 16'h0, 0, 0);
        repeat (3) cyc();
        chk("d3_count", vlog_rd.size() - n0, 2);
        exp_w("d3a", n0, 5, c0 + 5);
        exp_w("d3b", n0 + 1, 6, c0 + 6);

        // flush with rd 7 in MEM and rd 6 in WB; rd 8 offered during the flush
        c0 = cyc_n; n0 = vlog_rd.size();
        drive(1, 6, 16'hFFFF, 0, 0); cyc();
        drive(1, 7, 16'hFFFF, 0, 0); cyc();
        drive(1, 8, 16'hFFFF, 0, 0); bus.flush = 1; cyc();
        bus.flush = 0;
        drive(0, 0, 16'h0, 0, 0);
        repeat (3) cyc();
        chk("d4_count", vlog_rd.size() - n0, 1);
        exp_w("d4", n0, 6, c0 + 2);

        // three back-to-back v2i results with the integer core stalled
        bus.int_wb_ready = 0;
        c0 = cyc_n; n0 = vlog_rd.size(); i0 = ilog.size();
        drive(1, 1, 16'hFFFF, 1, 32'h11); cyc();
        drive(1, 2, 16'hFFFF, 1, 32'h22); cyc();
        drive(1, 3, 16'hFFFF, 1, 32'h33); cyc();
        drive(0, 0, 16'h0, 0, 0);
        repeat (4) cyc();
        chk("d5_ready_c3", rdy_log[c0 + 3], CAP == 2);
        bus.int_wb_ready = 1;
        repeat (6) cyc();
        chk("d5_vrf_none", vlog_rd.size() - n0, 0);
        chk("d5_count", ilog.size() - i0, 3);
        if (ilog.size() >= i0 + 3) begin
            chk("d5_first", ilog[i0], 32'h11);
            chk("d5_second", ilog[i0 + 1], 32'h22);
            chk("d5_third", ilog[i0 + 2], 32'h33);
        end

        // be = 0 entries retire without waiting on the VRF
        bus.vrf_wr_ready = 0;
        c0 = cyc_n; n0 = vlog_rd.size();
        for (int k = 0; k < 3; k++) begin drive(1, 12 + k, 16'h0, 0, 0); cyc(); end
        drive(0, 0, 16'h0, 0, 0);
        repeat (3) cyc();
        for (int k = 0; k < 6; k++) chk("d6_ready", rdy_log[c0 + k], 1);
        chk("d6_vrf_none", vlog_rd.size() - n0, 0);
        bus.vrf_wr_ready = 1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                  ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
                  $urandom_range(0, 3) == 0, $urandom);
            bus.flush        = $urandom_range(0, 9) == 0;
            bus.vrf_wr_ready = $urandom_range(0, 9) < 7;
            bus.int_wb_ready = $urandom_range(0, 9) < 6;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
